// File: rtl/local_inject_ni_if.sv
// Core-side handshake and router-side injection signals of the local NI.
// The slave modport is the NI itself; the master side is the core/router pair.
interface local_inject_ni_if #(
    parameter int FLIT_W     = 16,
    parameter int ADDR_W     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CREDITS    = 4
);
    logic                                 core_valid_i;
    logic                                 core_ready_o;
    logic [ADDR_W-1:0]                    core_dest_i;
    logic [FLIT_W-ADDR_W-1:0]             core_data_i;
    logic [FLIT_W-1:0]                    local_o;
    logic                                 local_valid_o;
    logic                                 credit_i;
    logic [$clog2(CREDITS+1)-1:0]         credits_o;
    logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count_o;
    logic [1:0]                           state_o;
    logic                                 credit_err_o;

    modport slave (
        input  core_valid_i, core_dest_i, core_data_i, credit_i,
        output core_ready_o, local_o, local_valid_o, credits_o,
               fifo_count_o, state_o, credit_err_o
    );

    modport master (
        output core_valid_i, core_dest_i, core_data_i, credit_i,
        input  core_ready_o, local_o, local_valid_o, credits_o,
               fifo_count_o, state_o, credit_err_o
    );
endinterface

// File: rtl/local_inject_ni.sv
// Local injection NI: packs {dest, data} into flits, queues them in a small FIFO
// and injects into the router's local input port under credit flow control.
module local_inject_ni #(
    parameter int FLIT_W     = 16,
    parameter int ADDR_W     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CREDITS    = 4
) (
    input logic              clk,
    input logic              rst,
    local_inject_ni_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH+1);
    localparam int CW = $clog2(CREDITS+1);
    localparam logic [NW-1:0] DEPTH_N = NW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CRED_N  = CW'(CREDITS);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SEND        = 2'd1,
        WAIT_CREDIT = 2'd2
    } state_e;

    logic [FLIT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [NW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     cred_q, cred_d;
    logic [FLIT_W-1:0] out_q;
    logic              vld_q;
    logic              err_q, err_d;
    state_e            state_q, state_d;
    logic              ready, push, send;

    // Sendability looks only at registered count, so a word pushed this
    // cycle into an empty FIFO waits one cycle before it can leave.
    always_comb begin
        ready = (cnt_q < DEPTH_N);
        push  = bus.core_valid_i && ready;
        send  = (cnt_q != '0) && (cred_q != '0);

        cnt_d = cnt_q;
        if (push && !send)      cnt_d = cnt_q + 1'b1;
        else if (!push && send) cnt_d = cnt_q - 1'b1;

        cred_d = cred_q;
        err_d  = err_q;
        if (send && !bus.credit_i) begin
            cred_d = cred_q - 1'b1;
        end else if (!send && bus.credit_i) begin
            if (cred_q == CRED_N) err_d  = 1'b1;
            else                  cred_d = cred_q + 1'b1;
        end

        if (cnt_d == '0)       state_d = IDLE;
        else if (cred_d != '0) state_d = SEND;
        else                   state_d = WAIT_CREDIT;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.core_dest_i, bus.core_data_i};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            cred_q   <= CRED_N;
            out_q    <= '0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
            state_q  <= IDLE;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (send) begin
                out_q    <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            vld_q   <= send;
            cnt_q   <= cnt_d;
            cred_q  <= cred_d;
            err_q   <= err_d;
            state_q <= state_d;
        end
    end

    assign bus.core_ready_o  = ready;
    assign bus.local_o       = out_q;
    assign bus.local_valid_o = vld_q;
    assign bus.credits_o     = cred_q;
    assign bus.fifo_count_o  = cnt_q;
    assign bus.state_o       = state_q;
    assign bus.credit_err_o  = err_q;
endmodule
